spi_master_gen2: RTL and testbench
==================================

Name: spi_master_gen2

Overview:
Parametrised SPI master, successor to the fixed 8-bit master. Configurable frame width, run-time CPOL/CPHA mode, programmable SCLK divider, and NUM_SS one-hot active-low slave selects. Sits between a host-side start/data handshake and one or more external SPI slaves. Runs entirely in the system clock domain; SCLK is a registered output.

Parameters:
DATA_W, 8, frame width in bits (>=2); MSB shifted first.
NUM_SS, 4, number of slave-select lines (>=1).
DIV_W, 8, width of the clock-divider input.
SS_W (localparam), max(1,$clog2(NUM_SS)), width of the slave index.

Ports:
i_spi_master_gen2_clk  in  1  system clock; all logic on rising edge.
i_spi_master_gen2_rst_n  in  1  asynchronous active-low reset.
i_spi_master_gen2_start  in  1  transfer request; accepted only when busy=0.
i_spi_master_gen2_tx_data  in  DATA_W  frame to transmit; latched on accept.
i_spi_master_gen2_ss_sel  in  SS_W  target slave index; latched on accept.
i_spi_master_gen2_cpol  in  1  SCLK idle level; latched on accept.
i_spi_master_gen2_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
i_spi_master_gen2_clk_div  in  DIV_W  SCLK half-period = clk_div+1 clocks; latched on accept.
i_spi_master_gen2_miso  in  1  serial data from the slaves.
o_spi_master_gen2_rx_data  out  DATA_W  last received frame; held until the next done.
o_spi_master_gen2_done  out  1  one-cycle pulse at the end of a frame.
o_spi_master_gen2_busy  out  1  high while a transfer is in progress.
o_spi_master_gen2_sclk  out  1  SPI clock.
o_spi_master_gen2_mosi  out  1  serial data to the slaves.
o_spi_master_gen2_ss_n  out  NUM_SS  active-low, one-hot-low slave selects.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): sclk=0, mosi=0, ss_n=all 1, rx_data=0, done=0, busy=0, FSM=IDLE, counters=0.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - start=1 with ss_sel<NUM_SS: accept on that edge (T0).
  - From T0: busy=1, ss_n[ss_sel]=0, sclk=cpol, mosi=tx_data[DATA_W-1] if cpha=0.
  - start with ss_sel>=NUM_SS is ignored: busy and done stay 0.
- Half-period counter: counts 0..clk_div; its terminal count is an "event".
- SETUP: lasts one half-period (clk_div+1 cycles). Ends at the first event.
- XFER:
  - 2*DATA_W events. Each event toggles sclk; edge index e = 0..2*DATA_W-1.
  - e even = leading edge; e odd = trailing edge.
  - CPHA=0: sample miso on leading edges; shift mosi to the next bit on trailing edges (no shift after the final edge).
  - CPHA=1: drive mosi with the next bit on leading edges (edge 0 drives the MSB); sample miso on trailing edges.
  - Sampling captures the miso value present at the clock edge that produces the sampling SCLK transition. Samples shift into the LSB of the rx shift register.
  - After the last edge, sclk = cpol.
- HOLD: one half-period with ss_n still asserted.
- DONE (one cycle):
  - ss_n = all 1, rx_data = shift register, done=1, busy=0.
  - done rises exactly (2*DATA_W+2)*(clk_div+1) cycles after T0.
  - Example: DATA_W=8, clk_div=0 gives 18 cycles.
  - A start in the DONE cycle is accepted (back-to-back). ss_n is then high for exactly that one cycle.
- start while busy=1 is ignored. Latched configuration cannot change mid-frame.
- clk_div=0: SCLK = clk/2. clk_div = 2^DIV_W-1 is legal, with no wrap artefacts.
- mosi holds its last bit between frames. rx_data changes only in DONE.

Optional Feature:
Macro SPI_MASTER_GEN2_LOOPBACK_EN.
- Defined: adds input i_spi_master_gen2_loopback (1 bit, latched on accept). When the latched value is 1, the sampler uses the internal mosi register instead of miso, and all ss_n stay high for the frame. Timing is unchanged.
- Undefined: port and mux absent; sampler always uses miso.

Decomposition:
- Shared package spi_gen2_pkg:
  - FSM state encoding (IDLE/SETUP/XFER/HOLD/DONE).
  - CPOL/CPHA mode constants.
  - Helper function for SS_W.
- One sub-module, spi_sclk_gen:
  - Half-period counter, edge index, sclk register.
  - Outputs: leading/trailing strobe and last-edge flag.

Test Plan:
- Basic frame: DATA_W=8, NUM_SS=4, div=0, mode 0, tx=0xA5, ss_sel=2, slave model returns 0x3C. Required: mosi sequence 1,0,1,0,0,1,0,1; ss_n=4'b1011 during the frame; rx_data=0x3C; done exactly 18 cycles after accept.
- Other modes: modes 1, 2, 3 with div=3. Required: sclk idles at cpol; 16 edges each 4 cycles apart; rx_data correct for each mode; done at 72 cycles.
- Start while busy: start with tx=0xFF at cycle 5 is ignored (frame stays 0xA5). Back-to-back start in the DONE cycle is accepted, with ss_n high for exactly 1 cycle.
- Reset mid-frame: assert rst_n=0 after edge 5. Required: immediately sclk=0, ss_n=4'b1111, busy=0, rx_data=0. A following frame completes correctly.
- Invalid slave: ss_sel=5 with NUM_SS=8 is accepted. ss_sel=3 with NUM_SS=3 (SS_W=2) is ignored: no busy, no done, ss_n unchanged.
- Loopback (macro defined): loopback=1, tx=0x5A, miso tied 0. Required: rx_data=0x5A, ss_n all high. With the macro undefined, the build has no loopback port.

Source files
------------

// File: rtl/spi_gen2_pkg.sv
// Shared definitions for the gen2 SPI master: FSM encoding, SPI mode constants,
// and the slave-index width helper.
package spi_gen2_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int ss_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_gen2_sclk_gen.sv
// SCLK generator: half-period counter, SCLK edge index and the SCLK register.
// Strobes are combinational and coincide with the clock edge that toggles sclk.
module spi_sclk_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             load,
  input  logic             cpol,
  input  logic             run,
  input  logic             xfer,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             last
);

  localparam int EW = $clog2(2*DATA_W);

  logic [DIV_W-1:0] cnt;
  logic [EW-1:0]    edge_idx;

  // cnt never passes div, so div = all-ones needs no wrap handling
  assign tick  = run && (cnt == div);
  assign lead  = tick && xfer && !edge_idx[0];
  assign trail = tick && xfer &&  edge_idx[0];
  assign last  = (edge_idx == EW'(2*DATA_W-1));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt      <= '0;
      edge_idx <= '0;
      sclk     <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      edge_idx <= '0;
      sclk     <= cpol;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && xfer) begin
        sclk     <= ~sclk;
        edge_idx <= edge_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// Parametrised SPI master with run-time CPOL/CPHA, SCLK divider and one-hot-low selects.
// Optional internal loopback (mosi -> sampler, selects held high): SPI_MASTER_GEN2_LOOPBACK_EN.
module spi_master_gen2 import spi_gen2_pkg::*; #(
  parameter  int DATA_W = 8,
  parameter  int NUM_SS = 4,
  parameter  int DIV_W  = 8,
  localparam int SS_W   = ss_width(NUM_SS)
) (
  input  logic              i_spi_master_gen2_clk,
  input  logic              i_spi_master_gen2_rst_n,
  input  logic              i_spi_master_gen2_start,
  input  logic [DATA_W-1:0] i_spi_master_gen2_tx_data,
  input  logic [SS_W-1:0]   i_spi_master_gen2_ss_sel,
  input  logic              i_spi_master_gen2_cpol,
  input  logic              i_spi_master_gen2_cpha,
  input  logic [DIV_W-1:0]  i_spi_master_gen2_clk_div,
  input  logic              i_spi_master_gen2_miso,
`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
  input  logic              i_spi_master_gen2_loopback,
`endif
  output logic [DATA_W-1:0] o_spi_master_gen2_rx_data,
  output logic              o_spi_master_gen2_done,
  output logic              o_spi_master_gen2_busy,
  output logic              o_spi_master_gen2_sclk,
  output logic              o_spi_master_gen2_mosi,
  output logic [NUM_SS-1:0] o_spi_master_gen2_ss_n
);

  logic [2:0]        state;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [DIV_W-1:0]  div_q;
  logic              cpha_q;
  logic              tick, lead, trail, last;
  logic              run, xfer, accept, shift, sample, sample_in;
  logic [31:0]       sel_ext;
  logic [NUM_SS-1:0] sel_mask;

  assign sel_ext = 32'(i_spi_master_gen2_ss_sel);
  // DONE counts as idle so a start there chains the next frame without a gap
  assign accept  = i_spi_master_gen2_start && (state == ST_IDLE || state == ST_DONE)
                   && (sel_ext < 32'(NUM_SS));
  assign run     = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
  assign xfer    = (state == ST_XFER);
  assign shift   = cpha_q ? lead : (trail && !last);
  assign sample  = cpha_q ? trail : lead;

`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
  logic lb_q;
  assign sample_in = lb_q ? o_spi_master_gen2_mosi : i_spi_master_gen2_miso;
  assign sel_mask  = i_spi_master_gen2_loopback ? '1
                   : ~(NUM_SS'(1) << i_spi_master_gen2_ss_sel);
  always_ff @(posedge i_spi_master_gen2_clk or negedge i_spi_master_gen2_rst_n) begin
    if (!i_spi_master_gen2_rst_n) lb_q <= 1'b0;
    else if (accept)              lb_q <= i_spi_master_gen2_loopback;
  end
`else
  assign sample_in = i_spi_master_gen2_miso;
  assign sel_mask  = ~(NUM_SS'(1) << i_spi_master_gen2_ss_sel);
`endif

  spi_sclk_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_sclk_gen (
    .gclk   (i_spi_master_gen2_clk),
    .grst_n (i_spi_master_gen2_rst_n),
    .load   (accept),
    .cpol   (i_spi_master_gen2_cpol),
    .run    (run),
    .xfer   (xfer),
    .div    (div_q),
    .sclk   (o_spi_master_gen2_sclk),
    .tick   (tick),
    .lead   (lead),
    .trail  (trail),
    .last   (last)
  );

  always_ff @(posedge i_spi_master_gen2_clk or negedge i_spi_master_gen2_rst_n) begin
    if (!i_spi_master_gen2_rst_n) begin
      state                     <= ST_IDLE;
      tx_sr                     <= '0;
      rx_sr                     <= '0;
      div_q                     <= '0;
      cpha_q                    <= 1'b0;
      o_spi_master_gen2_rx_data <= '0;
      o_spi_master_gen2_done    <= 1'b0;
      o_spi_master_gen2_busy    <= 1'b0;
      o_spi_master_gen2_mosi    <= 1'b0;
      o_spi_master_gen2_ss_n    <= '1;
    end else begin
      o_spi_master_gen2_done <= 1'b0;
      if (accept) begin
        state                  <= ST_SETUP;
        div_q                  <= i_spi_master_gen2_clk_div;
        cpha_q                 <= i_spi_master_gen2_cpha;
        o_spi_master_gen2_busy <= 1'b1;
        o_spi_master_gen2_ss_n <= sel_mask;
        // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on edge 0
        if (i_spi_master_gen2_cpha) begin
          tx_sr <= i_spi_master_gen2_tx_data;
        end else begin
          o_spi_master_gen2_mosi <= i_spi_master_gen2_tx_data[DATA_W-1];
          tx_sr                  <= i_spi_master_gen2_tx_data << 1;
        end
      end else begin
        case (state)
          ST_SETUP: if (tick) state <= ST_XFER;
          ST_XFER: begin
            if (shift) begin
              o_spi_master_gen2_mosi <= tx_sr[DATA_W-1];
              tx_sr                  <= tx_sr << 1;
            end
            if (sample) rx_sr <= {rx_sr[DATA_W-2:0], sample_in};
            if (tick && last) state <= ST_HOLD;
          end
          ST_HOLD: if (tick) begin
            state                     <= ST_DONE;
            o_spi_master_gen2_done    <= 1'b1;
            o_spi_master_gen2_busy    <= 1'b0;
            o_spi_master_gen2_ss_n    <= '1;
            o_spi_master_gen2_rx_data <= rx_sr;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Randomized bench for spi_master_gen2 against a behavioural SPI slave/timing model.
// Loopback checks are compiled in when SPI_MASTER_GEN2_LOOPBACK_EN is defined.
module tb_spi_master_gen2;

  logic       clk = 0, rst_n = 1, start = 0, cpol = 0, cpha = 0, miso = 0, lb = 0;
  logic [7:0] tx_data = 0, clk_div = 0;
  logic [1:0] ss_sel = 0;
  logic [7:0] rx_data;
  logic       done, busy, sclk, mosi;
  logic [3:0] ss_n;
  logic       start3 = 0, done3, busy3, sclk3, mosi3;
  logic [1:0] ss_sel3 = 0;
  logic [7:0] rx3;
  logic [2:0] ss_n3;
  logic       start8 = 0, done8, busy8, sclk8, mosi8;
  logic [2:0] ss_sel8 = 0;
  logic [7:0] rx8, ss_n8;

  int vec = 0, err = 0, cyc = 0;
  logic [7:0] cur_sw;
  logic       cur_pha;
  logic [3:0] cur_ss;
  int         cur_div;

  typedef struct {
    logic [7:0] rx, mosi_cap;
    logic [3:0] ss0, ss1;
    logic       busy0, sclk0, mosi0, busy1, sclk1;
    int         done_lat, n_edges, bad_gap, bad_ss, rx_moved;
    bit         timeout;
  } obs_t;

  spi_master_gen2 dut (
    .i_spi_master_gen2_clk(clk), .i_spi_master_gen2_rst_n(rst_n),
`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
    .i_spi_master_gen2_loopback(lb),
`endif
    .i_spi_master_gen2_start(start), .i_spi_master_gen2_tx_data(tx_data),
    .i_spi_master_gen2_ss_sel(ss_sel), .i_spi_master_gen2_cpol(cpol),
    .i_spi_master_gen2_cpha(cpha), .i_spi_master_gen2_clk_div(clk_div),
    .i_spi_master_gen2_miso(miso), .o_spi_master_gen2_rx_data(rx_data),
    .o_spi_master_gen2_done(done), .o_spi_master_gen2_busy(busy),
    .o_spi_master_gen2_sclk(sclk), .o_spi_master_gen2_mosi(mosi),
    .o_spi_master_gen2_ss_n(ss_n));

  spi_master_gen2 #(.NUM_SS(3)) dut3 (
    .i_spi_master_gen2_clk(clk), .i_spi_master_gen2_rst_n(rst_n),
`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
    .i_spi_master_gen2_loopback(1'b0),
`endif
    .i_spi_master_gen2_start(start3), .i_spi_master_gen2_tx_data(tx_data),
    .i_spi_master_gen2_ss_sel(ss_sel3), .i_spi_master_gen2_cpol(cpol),
    .i_spi_master_gen2_cpha(cpha), .i_spi_master_gen2_clk_div(clk_div),
    .i_spi_master_gen2_miso(miso), .o_spi_master_gen2_rx_data(rx3),
    .o_spi_master_gen2_done(done3), .o_spi_master_gen2_busy(busy3),
    .o_spi_master_gen2_sclk(sclk3), .o_spi_master_gen2_mosi(mosi3),
    .o_spi_master_gen2_ss_n(ss_n3));

  spi_master_gen2 #(.NUM_SS(8)) dut8 (
    .i_spi_master_gen2_clk(clk), .i_spi_master_gen2_rst_n(rst_n),
`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
    .i_spi_master_gen2_loopback(1'b0),
`endif
    .i_spi_master_gen2_start(start8), .i_spi_master_gen2_tx_data(tx_data),
    .i_spi_master_gen2_ss_sel(ss_sel8), .i_spi_master_gen2_cpol(cpol),
    .i_spi_master_gen2_cpha(cpha), .i_spi_master_gen2_clk_div(clk_div),
    .i_spi_master_gen2_miso(miso), .o_spi_master_gen2_rx_data(rx8),
    .o_spi_master_gen2_done(done8), .o_spi_master_gen2_busy(busy8),
    .o_spi_master_gen2_sclk(sclk8), .o_spi_master_gen2_mosi(mosi8),
    .o_spi_master_gen2_ss_n(ss_n8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a request; called at a negedge so it is accepted on the next posedge.
  task automatic kick(input logic [7:0] tx, input logic [7:0] sw, input logic [1:0] ss,
                      input logic [1:0] mode, input logic [7:0] div);
    tx_data = tx; ss_sel = ss; cpol = mode[1]; cpha = mode[0]; clk_div = div; start = 1;
    miso = sw[7];
    cur_sw = sw; cur_pha = mode[0]; cur_div = int'(div);
    cur_ss = lb ? 4'hF : ~(4'b0001 << ss);
  endtask

  // Acts as the SPI slave and records what the frame looked like, up to the done pulse.
  task automatic collect(input int poke_at, output obs_t o);
    int t0, last, n, b;
    logic prev;
    logic [7:0] rx0;
    @(negedge clk); start = 0;
    o = '{default: 0};
    t0 = cyc; last = t0; n = 0; prev = sclk; rx0 = rx_data;
    o.busy0 = busy; o.ss0 = ss_n; o.sclk0 = sclk; o.mosi0 = mosi; o.timeout = 1;
    for (int k = 1; k < 20000; k++) begin
      @(negedge clk);
      start = (k == poke_at);
      if (k == poke_at) tx_data = 8'hFF;
      if (done === 1'b1) begin o.timeout = 0; o.done_lat = cyc - t0; break; end
      if (ss_n !== cur_ss) o.bad_ss++;
      if (rx_data !== rx0) o.rx_moved++;
      if (sclk !== prev) begin
        if (cyc - last != ((n == 0) ? 2 : 1) * (cur_div + 1)) o.bad_gap++;
        last = cyc;
        if ((n % 2) == int'(cur_pha)) o.mosi_cap = {o.mosi_cap[6:0], mosi};
        n++;
      end
      prev = sclk;
      b = cur_pha ? ((n == 0) ? 0 : (n - 1) / 2) : n / 2;
      if (b > 7) b = 7;
      miso = cur_sw[7 - b];
    end
    o.n_edges = n; o.rx = rx_data; o.busy1 = busy; o.sclk1 = sclk; o.ss1 = ss_n;
  endtask

  task automatic test_reset();
    #1 rst_n = 0; #1;
    vec++; if ({sclk, mosi, done, busy} !== 4'b0000) begin err++; $display("FAIL reset_ctl: got %b want 0000", {sclk, mosi, done, busy}); end
    vec++; if (ss_n !== 4'hF) begin err++; $display("FAIL reset_ss_n: got %b want 1111", ss_n); end
    vec++; if (rx_data !== 8'h00) begin err++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    vec++; if ({ss_n3, ss_n8} !== 11'h7FF) begin err++; $display("FAIL reset_ss_other: got %h want 7ff", {ss_n3, ss_n8}); end
    repeat (2) @(negedge clk); rst_n = 1;
  endtask

  task automatic test_basic();
    obs_t o;
    @(negedge clk); kick(8'hA5, 8'h3C, 2'd2, 2'b00, 8'd0);
    collect(0, o);
    vec++; if (o.timeout) begin err++; $display("FAIL basic_timeout: no done within budget"); end
    vec++; if (o.busy0 !== 1'b1 || o.ss0 !== 4'b1011) begin err++; $display("FAIL basic_accept: busy %b ss_n %b want 1 1011", o.busy0, o.ss0); end
    vec++; if (o.mosi0 !== 1'b1) begin err++; $display("FAIL basic_mosi_t0: got %b want 1", o.mosi0); end
    vec++; if (o.mosi_cap !== 8'hA5) begin err++; $display("FAIL basic_mosi_seq: got %h want a5", o.mosi_cap); end
    vec++; if (o.rx !== 8'h3C) begin err++; $display("FAIL basic_rx: got %h want 3c", o.rx); end
    vec++; if (o.done_lat != 18) begin err++; $display("FAIL basic_latency: got %0d want 18", o.done_lat); end
    vec++; if (o.n_edges != 16 || o.bad_gap != 0) begin err++; $display("FAIL basic_edges: got %0d edges %0d bad gaps want 16 0", o.n_edges, o.bad_gap); end
    vec++; if (o.bad_ss != 0) begin err++; $display("FAIL basic_ss_hold: got %0d bad cycles want 0", o.bad_ss); end
    vec++; if (o.ss1 !== 4'hF || o.busy1 !== 1'b0) begin err++; $display("FAIL basic_done_state: ss_n %b busy %b want 1111 0", o.ss1, o.busy1); end
    @(negedge clk);
    vec++; if (done !== 1'b0 || rx_data !== 8'h3C) begin err++; $display("FAIL basic_after: done %b rx %h want 0 3c", done, rx_data); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int n;
    logic prev;
    logic [7:0] tx, sw;
    @(negedge clk); kick(8'hC3, 8'h96, 2'd3, 2'b10, 8'd1);
    @(negedge clk); start = 0; n = 0; prev = sclk;
    for (int k = 0; k < 200 && n < 6; k++) begin
      @(negedge clk);
      if (sclk !== prev) n++;
      prev = sclk;
    end
    vec++; if (n != 6) begin err++; $display("FAIL rstmid_edges: got %0d edges want 6", n); end
    rst_n = 0; #1;
    vec++; if (sclk !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL rstmid_ctl: sclk %b busy %b want 0 0", sclk, busy); end
    vec++; if (ss_n !== 4'hF || rx_data !== 8'h00) begin err++; $display("FAIL rstmid_out: ss_n %b rx %h want 1111 00", ss_n, rx_data); end
    @(negedge clk); rst_n = 1;
    tx = 8'($urandom); sw = 8'($urandom);
    @(negedge clk); kick(tx, sw, 2'd0, 2'b01, 8'd1);
    collect(0, o);
    vec++; if (o.rx !== sw || o.mosi_cap !== tx) begin err++; $display("FAIL rstmid_next: rx %h tx %h want %h %h", o.rx, o.mosi_cap, sw, tx); end
    vec++; if (o.done_lat != 36) begin err++; $display("FAIL rstmid_latency: got %0d want 36", o.done_lat); end
  endtask

  task automatic test_modes();
    obs_t o;
    logic [7:0] tx, sw;
    logic [1:0] m;
    for (int i = 1; i < 4; i++) begin
      m = 2'(i); tx = 8'($urandom); sw = 8'($urandom);
      @(negedge clk); kick(tx, sw, 2'($urandom_range(0, 3)), m, 8'd3);
      collect(0, o);
      vec++; if (o.sclk0 !== m[1] || o.sclk1 !== m[1]) begin err++; $display("FAIL mode%0d_idle: sclk %b/%b want %b", i, o.sclk0, o.sclk1, m[1]); end
      vec++; if (o.n_edges != 16 || o.bad_gap != 0) begin err++; $display("FAIL mode%0d_edges: got %0d edges %0d bad gaps want 16 0", i, o.n_edges, o.bad_gap); end
      vec++; if (o.done_lat != 72) begin err++; $display("FAIL mode%0d_latency: got %0d want 72", i, o.done_lat); end
      vec++; if (o.rx !== sw) begin err++; $display("FAIL mode%0d_rx: got %h want %h", i, o.rx, sw); end
      vec++; if (o.mosi_cap !== tx) begin err++; $display("FAIL mode%0d_mosi: got %h want %h", i, o.mosi_cap, tx); end
      vec++; if (o.bad_ss != 0) begin err++; $display("FAIL mode%0d_ss: got %0d bad cycles want 0", i, o.bad_ss); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [7:0] tx, sw, dv;
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom); sw = 8'($urandom); dv = 8'($urandom_range(0, 5));
      @(negedge clk); kick(tx, sw, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), dv);
      collect(0, o);
      vec++; if (o.rx !== sw || o.mosi_cap !== tx) begin err++; $display("FAIL rand%0d_data: rx %h tx %h want %h %h", i, o.rx, o.mosi_cap, sw, tx); end
      vec++; if (o.done_lat != 18 * (int'(dv) + 1) || o.bad_gap != 0) begin err++; $display("FAIL rand%0d_timing: lat %0d gaps %0d want %0d 0", i, o.done_lat, o.bad_gap, 18 * (int'(dv) + 1)); end
      vec++; if (o.rx_moved != 0) begin err++; $display("FAIL rand%0d_rx_hold: got %0d changes want 0", i, o.rx_moved); end
    end
  endtask

  task automatic test_busy_ignore();
    obs_t o;
    @(negedge clk); kick(8'hA5, 8'($urandom), 2'd1, 2'b00, 8'd0);
    collect(5, o);
    vec++; if (o.mosi_cap !== 8'hA5) begin err++; $display("FAIL busy_frame: got %h want a5", o.mosi_cap); end
    vec++; if (o.done_lat != 18) begin err++; $display("FAIL busy_latency: got %0d want 18", o.done_lat); end
    repeat (3) @(negedge clk);
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL busy_no_restart: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [7:0] tx2, sw2;
    tx2 = 8'($urandom); sw2 = 8'($urandom) | 8'h01;
    @(negedge clk); kick(8'($urandom), 8'h5E, 2'd0, 2'b11, 8'd1);
    collect(0, o1);
    kick(tx2, sw2, 2'd3, 2'b00, 8'd0);
    collect(0, o2);
    vec++; if (o1.ss1 !== 4'hF) begin err++; $display("FAIL b2b_gap_high: got %b want 1111", o1.ss1); end
    vec++; if (o2.ss0 !== 4'b0111 || o2.busy0 !== 1'b1) begin err++; $display("FAIL b2b_accept: ss_n %b busy %b want 0111 1", o2.ss0, o2.busy0); end
    vec++; if (o2.done_lat != 18 || o2.rx !== sw2) begin err++; $display("FAIL b2b_second: lat %0d rx %h want 18 %h", o2.done_lat, o2.rx, sw2); end
    vec++; if (o2.mosi_cap !== tx2 || o2.rx_moved != 0) begin err++; $display("FAIL b2b_tx_hold: tx %h rx changes %0d want %h 0", o2.mosi_cap, o2.rx_moved, tx2); end
  endtask

  task automatic test_max_div();
    obs_t o;
    logic [7:0] sw;
    sw = 8'($urandom);
    @(negedge clk); kick(8'($urandom), sw, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'hFF);
    collect(0, o);
    vec++; if (o.done_lat != 4608 || o.bad_gap != 0) begin err++; $display("FAIL maxdiv_timing: lat %0d gaps %0d want 4608 0", o.done_lat, o.bad_gap); end
    vec++; if (o.rx !== sw) begin err++; $display("FAIL maxdiv_rx: got %h want %h", o.rx, sw); end
  endtask

  task automatic test_invalid_ss();
    int bad;
    bit seen;
    clk_div = 8'd0; cpol = 0; cpha = 0;
    @(negedge clk);
    vec++; if ({rx3, sclk3, mosi3, rx8, sclk8, mosi8} !== 20'h0) begin err++; $display("FAIL sel_idle_outs: got %h want 0", {rx3, sclk3, mosi3, rx8, sclk8, mosi8}); end
    ss_sel3 = 2'd3; start3 = 1; ss_sel8 = 3'd5; start8 = 1;
    @(negedge clk); start3 = 0; start8 = 0; bad = 0;
    vec++; if (busy8 !== 1'b1 || ss_n8 !== 8'hDF) begin err++; $display("FAIL sel8_accept: busy %b ss_n %h want 1 df", busy8, ss_n8); end
    for (int k = 0; k < 25; k++) begin
      if (busy3 !== 1'b0 || done3 !== 1'b0 || ss_n3 !== 3'b111) bad++;
      @(negedge clk);
    end
    vec++; if (bad != 0) begin err++; $display("FAIL sel3_ignored: got %0d active cycles want 0", bad); end
    ss_sel3 = 2'd2; start3 = 1;
    @(negedge clk); start3 = 0;
    vec++; if (busy3 !== 1'b1 || ss_n3 !== 3'b011) begin err++; $display("FAIL sel3_valid: busy %b ss_n %b want 1 011", busy3, ss_n3); end
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done3 === 1'b1 && done8 === 1'b0) seen = 1;
    end
    vec++; if (!seen) begin err++; $display("FAIL sel3_done: got no done pulse want one"); end
  endtask

`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
  task automatic test_loopback();
    obs_t o;
    lb = 1;
    @(negedge clk); kick(8'h5A, 8'h00, 2'd1, 2'($urandom_range(0, 3)), 8'd1);
    collect(0, o);
    lb = 0;
    vec++; if (o.rx !== 8'h5A) begin err++; $display("FAIL loopback_rx: got %h want 5a", o.rx); end
    vec++; if (o.ss0 !== 4'hF || o.bad_ss != 0) begin err++; $display("FAIL loopback_ss: ss_n %b bad %0d want 1111 0", o.ss0, o.bad_ss); end
    vec++; if (o.done_lat != 36) begin err++; $display("FAIL loopback_latency: got %0d want 36", o.done_lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_modes();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_max_div();
    test_invalid_ss();
`ifdef SPI_MASTER_GEN2_LOOPBACK_EN
    test_loopback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
